rst_ctrl: RTL and testbench



---
 rtl/rst_ctrl_pkg.sv | 14 +
 rtl/clk_rst_if.sv | 13 +
 rtl/rst_sync.sv | 26 ++
 rtl/rst_ctrl.sv | 114 +++++++++++
 tb/tb_rst_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/rst_ctrl_pkg.sv
// Shared types and default constants for the reset controller and its users.
package rst_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        SW_HOLD,
        ACK
    } rst_state_e;

    localparam int RST_SYNC_STAGES_DEF = 2;
    localparam int RST_HOLD_CYCLES_DEF = 16;

endpackage

// File: rtl/clk_rst_if.sv
// Clock/reset bundle handed from the reset controller to downstream logic.
interface clk_rst_if;

    logic clk;
    logic arst;
    logic arstn;
    logic srst;
    logic srstn;

    modport source (output clk, arst, arstn, srst, srstn);
    modport sink   (input  clk, arst, arstn, srst, srstn);

endinterface

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchronizer; output rises STAGES edges after release.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arstn,
    output logic rstn
);

    if (STAGES < 2) begin : g_bad_stages
        $error("rst_sync: STAGES must be at least 2");
    end

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign rstn = chain[STAGES-1];

endmodule

// File: rtl/rst_ctrl.sv
// Reset controller: synchronized board reset, stretched synchronous reset and
// a four-phase software reset handshake, all presented on a clk_rst_if source.
module rst_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = RST_SYNC_STAGES_DEF,
    parameter int RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      arstn,
    input  logic      sw_rst_req,
    output logic      sw_rst_ack,
    output logic      rst_busy,
    clk_rst_if.source rst_if
);

    localparam int CNT_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RST_HOLD_CYCLES - 1);

    if (RST_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("rst_ctrl: RST_HOLD_CYCLES must be at least 1");
    end

    logic             sync_rstn;
    rst_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             srst_q, srst_d;
    logic             srstn_q;
    logic             busy_q;
    logic             ack_q, ack_d;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .arstn (arstn),
        .rstn  (sync_rstn)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are registered from the next-state decode so they change on the
    // same edge as the state, with no path from sw_rst_req to any output.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            srst_q  <= 1'b1;
            srstn_q <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= 1'b0;
        end else begin
            srst_q  <= srst_d;
            srstn_q <= ~srst_d;
            busy_q  <= srst_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HOLD: begin
                if (sync_rstn) begin
                    if (cnt_q == LAST) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (sw_rst_req) begin
                    state_d = SW_HOLD;
                    cnt_d   = '0;
                end
            end
            SW_HOLD: begin
                if (cnt_q == LAST) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                if (!sw_rst_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
        srst_d = (state_d == HOLD) || (state_d == SW_HOLD);
        ack_d  = (state_d == ACK);
    end

    assign rst_if.clk   = clk;
    assign rst_if.arstn = sync_rstn;
    assign rst_if.arst  = ~sync_rstn;
    assign rst_if.srst  = srst_q;
    assign rst_if.srstn = srstn_q;
    assign sw_rst_ack   = ack_q;
    assign rst_busy     = busy_q;

endmodule

// File: tb/tb_rst_ctrl.sv
// Scoreboard bench for rst_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_rst_ctrl;

    logic clk = 1'b0;
    logic arstn = 1'b1;
    logic sw_rst_req = 1'b0;
    logic sw_rst_ack;
    logic rst_busy;

    clk_rst_if rst_if_i ();

    rst_ctrl #(
        .SYNC_STAGES     (2),
        .RST_HOLD_CYCLES (16)
    ) dut (
        .clk        (clk),
        .arstn      (arstn),
        .sw_rst_req (sw_rst_req),
        .sw_rst_ack (sw_rst_ack),
        .rst_busy   (rst_busy),
        .rst_if     (rst_if_i)
    );

    always #5 clk = ~clk;

    // bit order: clk, arst, arstn, srst, srstn, busy, ack
    typedef struct {
        string      nm;
        logic [6:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [6:0] got;
    exp_t cur;

    function automatic void push(input string nm, input logic e_arstn,
                                 input logic e_srst, input logic e_ack);
        exp_t e;
        e.nm = nm;
        e.v  = {1'b0, ~e_arstn, e_arstn, e_srst, ~e_srst, e_srst, e_ack};
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            got = {rst_if_i.clk, rst_if_i.arst, rst_if_i.arstn, rst_if_i.srst,
                   rst_if_i.srstn, rst_busy, sw_rst_ack};
            n_checks++;
            if (got !== cur.v) begin
                $display("FAIL %s @%0t: got %b required %b (clk,arst,arstn,srst,srstn,busy,ack)",
                         cur.nm, $time, got, cur.v);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges 1..18 after release; req level for edge n+1 driven after edge n.
    task automatic release_seq(input int rf, input int rt);
        for (int n = 1; n <= 18; n++) begin
            step();
            push($sformatf("poweron_e%0d", n), n >= 2, n < 18, 1'b0);
            sw_rst_req = (n + 1 >= rf) && (n + 1 <= rt);
        end
    endtask

    task automatic power_on(input int low, input int rf, input int rt);
        arstn      = 1'b0;
        sw_rst_req = 1'b0;
        push("rst_assert_async", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < low; i++) begin
            step();
            push("rst_low", 1'b0, 1'b1, 1'b0);
        end
        step();
        arstn = 1'b1;
        push("rst_release", 1'b0, 1'b1, 1'b0);
        release_seq(rf, rt);
    endtask

    task automatic sw_reset(input int sticky);
        sw_rst_req = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            push($sformatf("sw_hold_c%0d", i), 1'b1, 1'b1, 1'b0);
        end
        step();
        push("sw_ack_rise", 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= sticky; i++) begin
            step();
            push($sformatf("sticky_c%0d", i), 1'b1, 1'b0, 1'b1);
        end
        sw_rst_req = 1'b0;
        step();
        push("sw_ack_fall", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            step();
            push(nm, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2 arstn = 1'b0;
        step();

        // power-on with a 5-cycle board reset
        power_on(5, 0, -1);
        idle(2, "run_idle");

        // software reset, then a sticky request held 10 cycles past ack
        sw_reset(0);
        idle(2, "run_after_sw");
        sw_reset(10);
        idle(2, "run_after_sticky");
        sw_reset(0);
        idle(1, "run_pre_abort");

        // board reset during SW_HOLD abandons the handshake
        sw_rst_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            push("sw_hold_pre_abort", 1'b1, 1'b1, 1'b0);
        end
        step();
        power_on(3, 0, -1);
        idle(2, "run_after_abort");

        // request held during HOLD is ignored
        step();
        power_on(3, 4, 10);
        idle(3, "run_req_in_hold");

        // request rising at edge 18 starts a SW reset at edge 19
        step();
        power_on(3, 18, 1000);
        sw_reset(0);
        idle(2, "run_after_late_req");

        // sub-half-period glitch on the board reset
        step();
        arstn = 1'b0;
        #2;
        arstn = 1'b1;
        push("glitch_async", 1'b0, 1'b1, 1'b0);
        release_seq(0, -1);
        idle(2, "run_after_glitch");

        step();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
